// File: rtl/cpu_test_pkg.sv
// rtl/cpu_test_pkg.sv - shared types, constants and slot helper for the CPU test sequencer
package cpu_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_RESET,
        ST_RUN,
        ST_RECORD,
        ST_DONE
    } seq_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 100000;

    // Packed slot buses are zero-extended to this width before slot_extract is applied.
    localparam int unsigned SLOT_BUS_MAX_W = 1024;
    localparam int unsigned SLOT_BUS_IDX_W = $clog2(SLOT_BUS_MAX_W);

    // Returns bit bit_idx of slot `slot` from a packed bus of `width`-bit slots.
    function automatic logic slot_extract(
        input logic [SLOT_BUS_MAX_W-1:0] bus,
        input int unsigned               slot,
        input int unsigned               width,
        input int unsigned               bit_idx
    );
        return bus[SLOT_BUS_IDX_W'(slot * width + bit_idx)];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating accumulator with synchronous clear
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;

    // Clear wins over increment; an overflowing add pins the count at all-ones.
    always_comb begin
        sum     = {1'b0, count_q} + {1'b0, inc};
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_test_sequencer.sv
// rtl/cpu_test_sequencer.sv - runs a table of CPU test vectors and records pass/fail and latency
module cpu_test_sequencer
    import cpu_test_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_TESTS  = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int unsigned RST_CYCLES = 1
) (
    input  logic                                                  clk,
    input  logic                                                  reset_n,
    input  logic                                                  start,
    input  logic [NUM_TESTS*DATA_W-1:0]                           test_in,
    input  logic [NUM_TESTS*DATA_W-1:0]                           test_exp,
    input  logic [NUM_TESTS-1:0]                                  test_en,
    input  logic [NUM_TESTS-1:0]                                  test_chain,
    output logic [DATA_W-1:0]                                     dut_in,
    output logic                                                  dut_reset,
    input  logic [DATA_W-1:0]                                     dut_out,
    output logic                                                  busy,
    output logic                                                  done,
    output logic [((NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1)-1:0]  cur_test,
    output logic [CNT_W-1:0]                                      cycle_count,
    output logic [CNT_W-1:0]                                      total_cycles,
    output logic [$clog2(NUM_TESTS+1)-1:0]                        pass_count,
    output logic [$clog2(NUM_TESTS+1)-1:0]                        fail_count,
    output logic [NUM_TESTS-1:0]                                  fail_mask
);

    localparam int unsigned IDX_W  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
    localparam int unsigned RES_W  = $clog2(NUM_TESTS + 1);
    // The slot pointer must reach NUM_TESTS to mean "past the last slot".
    localparam int unsigned PTR_W  = RES_W;
    localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);

    seq_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   cur_test_q, cur_test_d;
    logic [DATA_W-1:0]  dut_in_q, dut_in_d;
    logic               dut_reset_q, dut_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [RES_W-1:0]   pass_count_q, pass_count_d;
    logic [RES_W-1:0]   fail_count_q, fail_count_d;
    logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
    logic [RCNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic               first_q, first_d;
    logic               pass_q, pass_d;

    logic                      start_accept;
    logic                      seek_found;
    logic [IDX_W-1:0]          seek_idx;
    logic [DATA_W-1:0]         seek_in;
    logic [DATA_W-1:0]         cur_exp;
    logic [SLOT_BUS_MAX_W-1:0] test_in_ext;
    logic [SLOT_BUS_MAX_W-1:0] test_exp_ext;
    logic [CNT_W-1:0]          run_cnt;
    logic [CNT_W-1:0]          run_cnt_next;

    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign test_in_ext  = SLOT_BUS_MAX_W'(test_in);
    assign test_exp_ext = SLOT_BUS_MAX_W'(test_exp);
    assign run_cnt_next = run_cnt + CNT_W'(1);

    // Counts RUN cycles of the current test; held at zero outside RUN so each test starts fresh.
    sat_counter #(
        .WIDTH(CNT_W)
    ) u_run_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (state_q != ST_RUN),
        .en     (state_q == ST_RUN),
        .inc    (CNT_W'(1)),
        .count  (run_cnt)
    );

    // Accumulates the latency of each recorded test across the sequence.
    sat_counter #(
        .WIDTH(CNT_W)
    ) u_total_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (start_accept),
        .en     (state_q == ST_RECORD),
        .inc    (cycle_count_q),
        .count  (total_cycles)
    );

    // Lowest enabled slot at or above the pointer; scanning downwards leaves the lowest hit.
    always_comb begin
        seek_found = 1'b0;
        seek_idx   = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (test_en[i] && (i >= int'(ptr_q))) begin
                seek_found = 1'b1;
                seek_idx   = IDX_W'(i);
            end
        end
    end

    // Stimulus word of the slot being sought and expected word of the slot being run.
    always_comb begin
        seek_in = '0;
        cur_exp = '0;
        for (int unsigned b = 0; b < DATA_W; b++) begin
            seek_in[b] = slot_extract(test_in_ext, 32'(seek_idx), DATA_W, b);
            cur_exp[b] = slot_extract(test_exp_ext, 32'(cur_test_q), DATA_W, b);
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cur_test_d    = cur_test_q;
        dut_in_d      = dut_in_q;
        dut_reset_d   = dut_reset_q;
        busy_d        = busy_q;
        done_d        = done_q;
        cycle_count_d = cycle_count_q;
        pass_count_d  = pass_count_q;
        fail_count_d  = fail_count_q;
        fail_mask_d   = fail_mask_q;
        rst_cnt_d     = rst_cnt_q;
        first_d       = first_q;
        pass_d        = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pass_count_d = '0;
                    fail_count_d = '0;
                    fail_mask_d  = '0;
                    ptr_d        = '0;
                    first_d      = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    state_d      = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (!seek_found) begin
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    dut_reset_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cur_test_d = seek_idx;
                    dut_in_d   = seek_in;
                    first_d    = 1'b0;
                    // A chained slot keeps the CPU state left by the previous test.
                    if (test_chain[seek_idx] && !first_q) begin
                        dut_reset_d = 1'b0;
                        state_d     = ST_RUN;
                    end else begin
                        dut_reset_d = 1'b1;
                        rst_cnt_d   = '0;
                        state_d     = ST_RESET;
                    end
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RCNT_W'(RST_CYCLES - 1)) begin
                    dut_reset_d = 1'b0;
                    state_d     = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCNT_W'(1);
                end
            end
            ST_RUN: begin
                // Match is tested first so a match on the timeout cycle counts as a pass.
                if (dut_out == cur_exp) begin
                    pass_d        = 1'b1;
                    cycle_count_d = run_cnt_next;
                    state_d       = ST_RECORD;
                end else if (run_cnt_next >= CNT_W'(TIMEOUT)) begin
                    pass_d        = 1'b0;
                    cycle_count_d = CNT_W'(TIMEOUT);
                    state_d       = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (pass_q) begin
                    pass_count_d = pass_count_q + RES_W'(1);
                end else begin
                    fail_count_d            = fail_count_q + RES_W'(1);
                    fail_mask_d[cur_test_q] = 1'b1;
                end
                ptr_d   = PTR_W'(cur_test_q) + PTR_W'(1);
                state_d = ST_SEEK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the CPU in reset with all results cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cur_test_q    <= '0;
            dut_in_q      <= '0;
            dut_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
            pass_count_q  <= '0;
            fail_count_q  <= '0;
            fail_mask_q   <= '0;
            rst_cnt_q     <= '0;
            first_q       <= 1'b1;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cur_test_q    <= cur_test_d;
            dut_in_q      <= dut_in_d;
            dut_reset_q   <= dut_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cycle_count_q <= cycle_count_d;
            pass_count_q  <= pass_count_d;
            fail_count_q  <= fail_count_d;
            fail_mask_q   <= fail_mask_d;
            rst_cnt_q     <= rst_cnt_d;
            first_q       <= first_d;
            pass_q        <= pass_d;
        end
    end

    assign dut_in      = dut_in_q;
    assign dut_reset   = dut_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cur_test    = cur_test_q;
    assign cycle_count = cycle_count_q;
    assign pass_count  = pass_count_q;
    assign fail_count  = fail_count_q;
    assign fail_mask   = fail_mask_q;

endmodule

// File: doc/cpu_test_sequencer.md
Name: cpu_test_sequencer

Overview:
- Synthesisable, parametrised self-test sequencer for the 16-bit pipelined CPU.
- It replaces the hand-written reset / poll-until-output loop with hardware that runs up to NUM_TESTS test vectors back to back.
- For each vector it drives the CPU `in` bus, optionally pulses the CPU reset, counts cycles until the CPU `out` matches the expected value or a timeout expires, and then records pass/fail and latency.
- It sits beside the CPU in the FPGA top level and in simulation.

Parameters:
- DATA_W, 16: width of the CPU in/out buses.
- NUM_TESTS, 4: number of test slots.
- CNT_W, 32: width of the per-test and total cycle counters.
- TIMEOUT, 100000: maximum RUN cycles per test before it is declared failed.
- RST_CYCLES, 1: number of cycles the CPU reset is held high before RUN.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset of this block.
- start, input, 1: single-cycle pulse; begins a sequence when in IDLE or DONE.
- test_in, input, NUM_TESTS*DATA_W: packed stimulus words; slot i is bits [i*DATA_W +: DATA_W].
- test_exp, input, NUM_TESTS*DATA_W: packed expected CPU outputs, same packing as test_in.
- test_en, input, NUM_TESTS: per-slot enable; a disabled slot is skipped entirely.
- test_chain, input, NUM_TESTS: when bit i is 1, slot i runs without re-resetting the CPU.
- dut_in, output, DATA_W: drives the CPU `in` port.
- dut_reset, output, 1: drives the CPU `reset` port (active-high).
- dut_out, input, DATA_W: CPU `out` port.
- busy, output, 1: high from start acceptance until entry to DONE.
- done, output, 1: high while in DONE.
- cur_test, output, $clog2(NUM_TESTS): index of the slot being run.
- cycle_count, output, CNT_W: RUN cycles used by the most recently completed test.
- total_cycles, output, CNT_W: sum of RUN cycles of all completed tests in the sequence; saturates at all-ones.
- pass_count, output, $clog2(NUM_TESTS+1): number of passed tests.
- fail_count, output, $clog2(NUM_TESTS+1): number of failed tests.
- fail_mask, output, NUM_TESTS: bit i set if slot i timed out.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - dut_reset=1, so the CPU is held in reset while the sequencer is idle.
  - dut_in=0, busy=0, done=0, cur_test=0.
  - All counters and fail_mask are 0.
  - A reset asserted mid-sequence aborts immediately; no partial results are kept.
- States: IDLE, SEEK, RESET, RUN, RECORD, DONE.
- IDLE / DONE:
  - On start: clear pass_count, fail_count, fail_mask and total_cycles; set slot pointer to 0; go to SEEK; busy=1.
  - start in any other state is ignored.
- SEEK (1 cycle):
  - If no enabled slot exists at or above the pointer, go to DONE.
  - Otherwise load cur_test with the lowest enabled slot at or above the pointer and set dut_in = test_in[slot].
  - If test_chain[slot]=1 and this is not the first executed test of the sequence, go to RUN; else go to RESET.
  - test_chain is ignored for the first executed test.
- RESET:
  - dut_reset=1 for exactly RST_CYCLES cycles; dut_in stays stable.
  - Then deassert dut_reset and go to RUN.
- RUN:
  - dut_reset=0.
  - The internal counter increments every cycle, and dut_out is compared against test_exp[cur_test] each cycle.
  - On a match, go to RECORD as a pass; cycle_count records the counter value including the match cycle, so a match on the first RUN cycle gives 1.
  - If the counter reaches TIMEOUT without a match, go to RECORD as a fail with cycle_count=TIMEOUT.
  - If a match and the timeout occur on the same cycle, the match wins.
- RECORD (1 cycle):
  - Update pass_count or fail_count and fail_mask[cur_test].
  - Add the test's cycles to total_cycles, saturating.
  - Set pointer = cur_test+1 and go to SEEK.
  - dut_in and dut_reset are held through this state.
- DONE:
  - done=1, busy=0, dut_reset=1.
  - All results are held stable until the next start or reset.
- Every output is registered; no combinational path from dut_out to any output.

Decomposition:
- Shared package cpu_test_pkg contains:
  - the state enum (IDLE..DONE);
  - a default TIMEOUT constant;
  - a slot-extract function for the packed buses.
- One natural sub-module: sat_counter (parametrised width, increment, synchronous clear, saturate), used for total_cycles and the RUN cycle counter.

Test Plan:
- Single pass:
  - Setup: NUM_TESTS=1, test_in=0x13B0, exp=0x000B; bench CPU model outputs 0x000B on the 7th cycle after reset release.
  - Expected: pass_count=1, fail_count=0, cycle_count=7, done=1.
- Chained pair:
  - Setup: slot0 0x0906 expecting 13 after 5 cycles; slot1 0x754E expecting 17 after 4 cycles, with test_chain[1]=1.
  - Expected: dut_reset is not pulsed between tests; pass_count=2; total_cycles=9.
- Timeout:
  - Setup: TIMEOUT=20; model never matches slot 2.
  - Expected: fail_count=1, fail_mask=4'b0100, cycle_count=20; the sequence continues to slot 3.
- Skip:
  - Setup: test_en=4'b1010.
  - Expected: only slots 1 and 3 execute (cur_test takes only those values); pass_count+fail_count=2.
- Simultaneous events:
  - Setup: the match lands on cycle TIMEOUT.
  - Expected: recorded as a pass; start pulsed during RUN is ignored.
- Abort:
  - Setup: reset_n driven low mid-RUN.
  - Expected: outputs immediately return to reset values with dut_reset=1; a later start reruns from slot 0.
